// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared state encoding and constants for the stopwatch controller
// Contents:
//   sw_state_t          3-bit FSM state encoding (IDLE=0, RUN=1, LAP=2, STOP=3, CLEAR=4)
//   SW_DEBOUNCE_DEFAULT default debounce length in clk cycles (10 ms at 100 MHz)
//   SW_CLK_HZ           nominal system clock frequency
package stopwatch_pkg;

  typedef enum logic [2:0] {
    SW_IDLE  = 3'd0,
    SW_RUN   = 3'd1,
    SW_LAP   = 3'd2,
    SW_STOP  = 3'd3,
    SW_CLEAR = 3'd4
  } sw_state_t;

  localparam int SW_DEBOUNCE_DEFAULT = 1000000;
  localparam int SW_CLK_HZ           = 100000000;

endpackage

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - two-flop synchroniser, debouncer and press-pulse generator for one button
// Ports:
//   clk      in  system clock
//   reset    in  asynchronous, active-high
//   btn_raw  in  raw button level, asynchronous to clk
//   press    out one-cycle pulse after each accepted 0->1 debounced transition
// Parameters:
//   DEBOUNCE_CYCLES  consecutive differing samples needed to flip the debounced level (>= 2)
module button_debounce
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = SW_DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic press
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES);

  logic [1:0]      sync_q;
  logic            level_q;
  logic            level_d_q;
  logic [DB_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], btn_raw};
    end
  end

  // The counter only runs while the synced sample disagrees with the accepted
  // level; any agreeing sample restarts the qualification window. Reaching
  // the last count flips the level instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else if (sync_q[1] == level_q) begin
      cnt_q <= '0;
    end else if (cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
      cnt_q   <= '0;
      level_q <= sync_q[1];
    end else begin
      cnt_q <= cnt_q + DB_W'(1);
    end
  end

  // Edge detect on the registered level; the pulse lands one cycle after the
  // level rises and releases produce nothing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_d_q <= 1'b0;
      press     <= 1'b0;
    end else begin
      level_d_q <= level_q;
      press     <= level_q & ~level_d_q;
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - button-driven Moore FSM sequencing the stopwatch counter and display
// Ports:
//   clk           in  system clock, 100 MHz
//   reset         in  asynchronous, active-high
//   btn_ss_raw    in  raw start/stop button
//   btn_lr_raw    in  raw lap/reset button
//   count_at_max  in  counter at terminal value (level)
//   count_en      out counter increment enable (RUN, LAP)
//   count_clr     out one-cycle counter clear (CLEAR)
//   display_hold  out display freeze (LAP)
//   state_o       out current state encoding
// Build option: STOPWATCH_LAP_EN enables the LAP state and display_hold;
// without it lr only acts in STOP (clear) and encoding 2 is illegal.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = SW_DEBOUNCE_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_ss_raw,
  input  logic       btn_lr_raw,
  input  logic       count_at_max,
  output logic       count_en,
  output logic       count_clr,
  output logic       display_hold,
  output logic [2:0] state_o
);

  localparam logic [2:0] ST_IDLE  = SW_IDLE;
  localparam logic [2:0] ST_RUN   = SW_RUN;
  localparam logic [2:0] ST_STOP  = SW_STOP;
  localparam logic [2:0] ST_CLEAR = SW_CLEAR;
`ifdef STOPWATCH_LAP_EN
  localparam logic [2:0] ST_LAP   = SW_LAP;
`endif

  logic       ss_pulse;
  logic       lr_pulse;
  logic [2:0] state;
  logic [2:0] next_state;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_ss (
    .clk     (clk),
    .reset   (reset),
    .btn_raw (btn_ss_raw),
    .press   (ss_pulse)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_lr (
    .clk     (clk),
    .reset   (reset),
    .btn_raw (btn_lr_raw),
    .press   (lr_pulse)
  );

  // Branch order encodes priority: count_at_max over ss over lr, so a
  // coincident lr is simply dropped.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (ss_pulse) next_state = ST_RUN;
      end
      ST_RUN: begin
        if (count_at_max)  next_state = ST_STOP;
        else if (ss_pulse) next_state = ST_STOP;
`ifdef STOPWATCH_LAP_EN
        else if (lr_pulse) next_state = ST_LAP;
`endif
      end
`ifdef STOPWATCH_LAP_EN
      ST_LAP: begin
        if (count_at_max)  next_state = ST_STOP;
        else if (ss_pulse) next_state = ST_STOP;
        else if (lr_pulse) next_state = ST_RUN;
      end
`endif
      ST_STOP: begin
        if (ss_pulse)      next_state = ST_RUN;
        else if (lr_pulse) next_state = ST_CLEAR;
      end
      ST_CLEAR: begin
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Pure decode of the state register; CLEAR lasts one cycle so count_clr does too.
  assign count_clr = (state == ST_CLEAR);
  assign state_o   = state;
`ifdef STOPWATCH_LAP_EN
  assign count_en     = (state == ST_RUN) || (state == ST_LAP);
  assign display_hold = (state == ST_LAP);
`else
  assign count_en     = (state == ST_RUN);
  assign display_hold = 1'b0;
`endif

endmodule
